// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline boundary register (pipe_stage_elastic / pipe_slice).
package pipe_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_FULL  = 2'b01,
        SLOT_SKID  = 2'b10
    } slot_state_e;

    localparam int PIPE_MAX_STAGES = 4;

    // Number of payload entries a slice holds in a given state.
    function automatic logic [1:0] slot_weight(input slot_state_e s);
        case (s)
            SLOT_FULL: return 2'd1;
            SLOT_SKID: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic slice: main entry plus an optional skid entry (PIPE_STAGE_SKID_EN).
// en=0 freezes the slice, clr empties it on the next edge without touching data.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output slot_state_e      slot_state,
    output logic [1:0]       weight_next
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
`endif

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (clr) begin
            state_d = SLOT_EMPTY;
        end else if (en) begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (up_valid) begin
                        state_d = SLOT_FULL;
                        main_d  = up_data;
                    end
                end
                SLOT_FULL: begin
                    if (up_valid && dn_ready) begin
                        main_d = up_data;
                    end else if (dn_ready) begin
                        state_d = SLOT_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (up_valid) begin
                        state_d = SLOT_SKID;
                        skid_d  = up_data;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                SLOT_SKID: begin
                    if (dn_ready) begin
                        state_d = SLOT_FULL;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = SLOT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            main_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign up_ready = (state_q != SLOT_SKID);
`else
    assign up_ready = (state_q == SLOT_EMPTY) || dn_ready;
`endif
    assign dn_valid    = (state_q != SLOT_EMPTY);
    assign dn_data     = main_q;
    assign slot_state  = state_q;
    assign weight_next = slot_weight(state_d);

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline boundary: STAGES chained pipe_slice instances with stall/flush masking
// and a registered occupancy count. Skid entries are built when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             stall,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W    = $clog2(2*STAGES+1);
    localparam int N_SLICES = (STAGES > PIPE_MAX_STAGES) ? PIPE_MAX_STAGES : STAGES;

    logic                          pass;
    logic [N_SLICES-1:0]           up_valid_v;
    logic [N_SLICES-1:0]           up_ready_v;
    logic [N_SLICES-1:0]           dn_valid_v;
    logic [N_SLICES-1:0]           dn_ready_v;
    logic [WIDTH-1:0]              up_data_v [N_SLICES];
    logic [WIDTH-1:0]              dn_data_v [N_SLICES];
    slot_state_e [N_SLICES-1:0]    slot_st;
    logic [N_SLICES-1:0][1:0]      weight_next;
    logic [OCC_W-1:0]              occ_d, occ_q;
    logic                          unused_up_ready;

    assign pass = !stall && !flush;

    always_comb begin
        up_valid_v    = '0;
        up_valid_v[0] = in_valid;
        up_data_v[0]  = in_data;
        for (int i = 1; i < N_SLICES; i++) begin
            up_valid_v[i] = dn_valid_v[i-1];
            up_data_v[i]  = dn_data_v[i-1];
        end
    end

    // Downstream ready of each slice is derived from registered slot states so the
    // ready vector never feeds back on itself.
    always_comb begin
        dn_ready_v             = '0;
        dn_ready_v[N_SLICES-1] = out_ready;
        for (int i = 0; i < N_SLICES-1; i++) begin
`ifdef PIPE_STAGE_SKID_EN
            dn_ready_v[i] = (slot_st[i+1] != SLOT_SKID);
`else
            dn_ready_v[i] = out_ready;
            for (int j = i + 1; j < N_SLICES; j++) begin
                if (slot_st[j] == SLOT_EMPTY) dn_ready_v[i] = 1'b1;
            end
`endif
        end
    end

    for (genvar g = 0; g < N_SLICES; g++) begin : g_slice
        pipe_slice #(.WIDTH(WIDTH)) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (!stall),
            .clr         (flush),
            .up_valid    (up_valid_v[g]),
            .up_ready    (up_ready_v[g]),
            .up_data     (up_data_v[g]),
            .dn_valid    (dn_valid_v[g]),
            .dn_ready    (dn_ready_v[g]),
            .dn_data     (dn_data_v[g]),
            .slot_state  (slot_st[g]),
            .weight_next (weight_next[g])
        );
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            occ_d = occ_d + OCC_W'(weight_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign unused_up_ready = ^up_ready_v;

    assign in_ready  = up_ready_v[0] && pass;
    assign out_valid = dn_valid_v[N_SLICES-1] && pass;
    assign out_data  = dn_data_v[N_SLICES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic (WIDTH=32, STAGES=2): directed vectors plus a FIFO-queue model
// checked every cycle. Adapts its capacity expectations to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_elastic;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int OCC_W  = $clog2(2*STAGES+1);
`ifdef PIPE_STAGE_SKID_EN
    localparam int MAX_OCC  = 2*STAGES;
    localparam bit SKID_ON  = 1'b1;
`else
    localparam int MAX_OCC  = STAGES;
    localparam bit SKID_ON  = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_in    = 0;
    int n_out   = 0;
    logic [WIDTH-1:0] model_q [$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the block is a FIFO; entries held = accepted - delivered since the last flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            check("occ_model", occupancy, model_q.size());
            check("occ_bound", (occupancy <= MAX_OCC), 1);
            if (stall || flush) begin
                check("mask_in_ready", in_ready, 0);
                check("mask_out_valid", out_valid, 0);
            end
            if (model_q.size() == 0) begin
                check("empty_out_valid", out_valid, 0);
                check("empty_in_ready", in_ready, !stall && !flush);
            end else if (out_valid) begin
                check("out_order", out_data, model_q[0]);
            end
            if (model_q.size() >= MAX_OCC)
                check("full_in_ready", in_ready, (SKID_ON ? 1'b0 : out_ready) && !stall && !flush);
            if (flush) begin
                model_q.delete();
            end else begin
                if (out_valid && out_ready && model_q.size() > 0) begin
                    void'(model_q.pop_front());
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    model_q.push_back(in_data);
                    n_in++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int fill;
        int base_out;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);

        // Back-to-back stream 1..8 with downstream always ready.
        out_ready = 1'b1;
        for (int c = 0; c < 8 + STAGES + 2; c++) begin
            in_valid = (c < 8);
            in_data  = WIDTH'(c + 1);
            #1;
            if (c < 8) check("stream_in_ready", in_ready, 1);
            check("stream_out_valid", out_valid, (c >= STAGES) && (c < 8 + STAGES));
            if ((c >= STAGES) && (c < 8 + STAGES)) check("stream_out_data", out_data, c - STAGES + 1);
            tick();
        end
        in_valid = 1'b0;

        // Backpressure: capacity fills, then release drains in order and input resumes.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int c = 0; c < MAX_OCC + 4; c++) begin
            in_data = 32'hA0 + acc;
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_data = 32'hA0 + acc;
        #1;
        check("bp_accepted", acc, MAX_OCC);
        check("bp_in_ready", in_ready, 0);
        check("bp_occupancy", occupancy, MAX_OCC);
        check("bp_head_data", out_data, 32'hA0);
        out_ready = 1'b1;
        #1;
        check("bp_release_valid", out_valid, 1);
        tick();
        check("bp_second_data", out_data, 32'hA1);
        for (int c = 0; c < 20 && acc < MAX_OCC + 2; c++) begin
            in_data = 32'hA0 + acc;
            #1;
            if (in_ready) acc++;
            tick();
        end
        check("bp_resume", acc, MAX_OCC + 2);
        in_valid = 1'b0;
        repeat (3 * STAGES + 4) tick();
        check("bp_drained", occupancy, 0);

        // Flush with several entries held while upstream is still offering.
        fill = (MAX_OCC < 3) ? MAX_OCC : 3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int c = 0; c < 12 && acc < fill; c++) begin
            in_data = 32'hF0 + acc;
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("flush_pre_occ", occupancy, fill);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hEE;
        #1;
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_occ_zero", occupancy, 0);
        check("flush_post_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 32'h55;
        #1;
        check("flush_no_dead_cycle", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3 * STAGES + 2) tick();
        check("flush_drained", occupancy, 0);

        // Stall for 3 cycles in the middle of a stream.
        base_out = n_out;
        acc = 0;
        for (int c = 0; c < 11; c++) begin
            stall    = (c >= 4) && (c < 7);
            in_valid = 1'b1;
            in_data  = 32'h100 + acc;
            #1;
            if (stall) begin
                check("stall_occ_held", occupancy, STAGES);
                check("stall_data_held", out_data, 32'h100 + 4 - STAGES);
            end
            if (c == 7) begin
                check("stall_resume_ready", in_ready, 1);
                check("stall_resume_valid", out_valid, 1);
                check("stall_resume_data", out_data, 32'h100 + 4 - STAGES);
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        repeat (3 * STAGES + 2) tick();
        check("stall_accepts", acc, 8);
        check("stall_delivered", n_out - base_out, 8);

        // Asynchronous reset in the middle of a cycle with two entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            in_data = 32'h200 + acc;
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("ar_pre_occ", occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_occupancy", occupancy, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_out_data", out_data, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h2FF;
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("ar_no_accept", occupancy, 0);
        check("ar_post_valid", out_valid, 0);
        tick();

        // Random downstream readiness over 200 items.
        base_out = n_out;
        acc = 0;
        for (int c = 0; c < 4000 && acc < 200; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 32'h1000 + acc;
            #1;
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (n_out - base_out) < 200; c++) tick();
        check("rand_accepts", acc, 200);
        check("rand_delivered", n_out - base_out, 200);
        check("rand_final_occ", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline boundary register that replaces the fixed, always-enabled 32-bit/5-bit stage registers between FE/DE/EX/ME/WB. It carries an arbitrary-width payload through `STAGES` chained slices with a valid/ready handshake, hazard-unit stall and branch flush. An optional skid entry per slice keeps `in_ready` fully registered. It sits between two pipeline stages, and the hazard unit drives its `stall` and `flush` inputs.

## Interface
- `WIDTH`, default 32: payload width in bits (1..256).
- `STAGES`, default 1: number of chained slices (1..4).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard-unit freeze; no transfer on either side, state holds.
- `flush` input 1: branch/mispredict clear; all slices empty on the next edge.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output WIDTH: payload of the oldest entry.
- `occupancy` output $clog2(2*STAGES+1): number of entries held, counting main and skid entries.

## Operation
- A handshake completes on either side only when valid and ready are both 1 at the rising edge.
- Each slice holds a `main` entry and a `skid` entry, and has the states EMPTY, FULL and SKID.
  - EMPTY: `up_valid` → FULL with `main<=up_data`.
  - FULL with `up_valid & dn_ready`: stay FULL, `main<=up_data`.
  - FULL with `!up_valid & dn_ready`: → EMPTY.
  - FULL with `up_valid & !dn_ready`: → SKID, `skid<=up_data`.
  - FULL otherwise: hold.
  - SKID with `dn_ready`: → FULL, `main<=skid`.
  - SKID otherwise: hold.
- Slice outputs: `up_ready = (state!=SKID)`, `dn_valid = (state!=EMPTY)`, `dn_data = main`.
- Slices are chained. Slice 0 faces `in_*` and slice STAGES-1 faces `out_*`.
- Stall: `in_ready` and `out_valid` are masked to 0, so no handshakes occur. Every slice holds its state and data.
- Flush: `in_ready` and `out_valid` are masked to 0, and every slice goes to EMPTY at the next edge. Data registers are not cleared.
- Priority is `flush` > `stall` > normal operation.
- `occupancy` is registered and equals the sum over slices of (FULL=1, SKID=2, EMPTY=0). It is 0 after flush.
- Reset: all slices EMPTY and main/skid = 0. Outputs after reset: `out_valid=0`, `in_ready=1`, `out_data=0`, `occupancy=0`.
- Reset asserted mid-operation drops all entries immediately (asynchronous). No handshake completes while `rst_n=0`.

## Timing
- Latency is STAGES cycles from input accept to `out_valid`, with `out_ready` held at 1.
- Sustained throughput is 1 item per cycle.
- `in_ready` depends only on slice-0 state plus `stall`/`flush`. There is no combinational path from `out_ready` to `in_ready` when the skid entry is present.
- On the first cycle after `flush`/`stall` deassert, normal handshakes resume with no dead cycle.
- Ordering is strictly FIFO. No entry is dropped or duplicated under any mix of `stall`, `out_ready` and `in_valid`.

## Configuration
- The `PIPE_STAGE_SKID_EN` macro controls the skid entry.
- When it is defined:
  - the skid entry and the SKID state exist, as described above;
  - `in_ready` is registered;
  - maximum occupancy is 2*STAGES.
- When it is undefined:
  - each slice is single-entry with states EMPTY/FULL;
  - `up_ready = (state==EMPTY) | dn_ready`, a combinational ready chain;
  - maximum occupancy is STAGES, and the port width is unchanged.

## Structure
- Package `pipe_pkg` holds `typedef enum logic [1:0] {SLOT_EMPTY=2'b00, SLOT_FULL=2'b01, SLOT_SKID=2'b10} slot_state_e` and the constant `PIPE_MAX_STAGES=4`.
- Sub-module `pipe_slice` is parametrised by WIDTH and contains a single slice FSM. The top instantiates it STAGES times with a generate loop, and applies the stall/flush masking and the occupancy sum.

## Test plan
- Reset then stream: with WIDTH=32, STAGES=2 and `out_ready=1`, send 0x1..0x8 back-to-back → `out_data` shows 0x1..0x8 in order. The first `out_valid` appears 2 cycles after the first accept, and one item follows per cycle.
- Backpressure: with skid enabled and STAGES=1, hold `out_ready=0` and offer 0xA, 0xB, 0xC. Only 0xA and 0xB are accepted, `in_ready`=0 and `occupancy`=2. Release → output is 0xA then 0xB, and 0xC is then accepted.
- Flush: with occupancy 3, assert `flush` for 1 cycle while `in_valid=1` → no accept, `out_valid=0`, and next cycle `occupancy=0`.
- Stall: assert `stall` for 3 cycles with `out_ready=1` and `in_valid=1` → no handshakes and data held. After release the stream continues with no loss.
- Async reset: with occupancy 2, pulse `rst_n=0` mid-cycle → `out_valid` and `occupancy` go to 0 immediately and `in_ready` goes to 1.
- Macro off: with `out_ready` toggling randomly 50% over 200 items → output order and count match the input, and `occupancy` never exceeds STAGES.
